uart_tx_framer: RTL and testbench
=================================

Name: uart_tx_framer

Overview:
Serial transmit stage that sits directly upstream of the receive pipeline. It drives the single-bit line that the receiver samples on its dout input.
- Accepts one byte per handshake and serialises it as start bit, 7 or 8 data bits LSB first, optional parity bit, then 1 or 2 stop bits.
- Line rate comes from an internal bit-period counter running on the system clock; no derived clock is used.
- Frame-format inputs (bd_rate, dnum, snum, par) are encoded identically to the receive side, so both ends are configured from the same signals.

Parameters:
DIV0, 5208, clock cycles per bit when bd_rate=00 (must be >=2)
DIV1, 2604, clock cycles per bit when bd_rate=01 (>=2)
DIV2, 1302, clock cycles per bit when bd_rate=10 (>=2)
DIV3, 434, clock cycles per bit when bd_rate=11 (>=2)

Ports:
clk  input  1  system clock, all logic on rising edge
rst  input  1  reset, asynchronous, active-high
bd_rate  input  2  bit-period select (DIV0..DIV3)
dnum  input  1  0 = 7 data bits (din[6:0]), 1 = 8 data bits
snum  input  1  0 = 1 stop bit, 1 = 2 stop bits
par  input  2  00 none, 01 odd, 10 even, 11 none
din  input  8  byte to transmit
din_valid  input  1  producer has a byte
din_ready  output  1  block can accept a byte
dout  output  1  serial line, idle high
tx_busy  output  1  frame in progress
tx_done  output  1  one-cycle pulse after final stop bit

Behaviour:
- Reset (async, any time including mid-frame): dout=1, din_ready=1, tx_busy=0, tx_done=0, state=IDLE, all counters and shift register cleared. A partially sent frame is abandoned; there is no resume.
- All outputs are registered.
- FSM states: IDLE, START, DATA, PARITY, STOP.
- IDLE:
  - din_ready=1, tx_busy=0, dout=1.
  - Accept occurs on an edge where din_valid=1 and din_ready=1.
  - On accept, latch din, dnum, snum, par, and the divisor selected by bd_rate.
  - Compute and latch parity over the transmitted bits only: din[6:0] when dnum=0, din[7:0] when dnum=1.
  - Odd mode makes the total count of ones (data + parity) odd; even mode makes it even.
  - Go to START.
- Latency: accept at edge k gives dout=0 from edge k+1. din_ready and tx_busy change at edge k+1.
- Input changes after accept: config inputs and din are ignored until the next accept.
- Bit timing:
  - A period counter loads DIV-1 on entering each bit and counts down.
  - The bit ends at the edge where the counter equals 0.
  - Every bit, including each stop bit, lasts exactly DIV clocks.
- START: dout=0 for one bit, then go to DATA with bit index 0.
- DATA:
  - dout = latched data[index], LSB first.
  - After index 6 (dnum=0) or index 7 (dnum=1), go to PARITY if par is 01 or 10, else to STOP.
- PARITY: dout = latched parity bit for one bit, then go to STOP.
- STOP:
  - dout=1 for 1 bit (snum=0) or 2 bits (snum=1).
  - At the end, go to IDLE and pulse tx_done=1 for exactly the first IDLE cycle.
- Frame length: DIV*(1+N+P+S) cycles from the first start-bit cycle to the last stop-bit cycle inclusive, where N=7/8, P=0/1, S=1/2.
- Back-to-back: din_ready=1 during the tx_done cycle. If din_valid=1 then, the byte is accepted and the next start bit begins the following cycle. The inter-frame gap is therefore exactly 1 idle cycle (dout=1).
- din_valid held high continuously: one byte is accepted per frame, with no duplicate accept while busy.
- bd_rate=11 with par=11 is legal and means no parity.
- Divisor values <2 are unsupported; a bench asserts on elaboration.

Test Plan:
- DIV0=4, bd_rate=00, dnum=1, snum=0, par=00, din=0x55 pulse -> dout 0 for 4 clk, then 1,0,1,0,1,0,1,0 each 4 clk, then 1 for 4 clk. Frame is 40 clk; tx_done pulses once at cycle 41.
- dnum=1, par=10 (even), din=0xA5 -> parity bit 0. Same byte with par=01 (odd) -> parity bit 1. Frame is 44 clk with DIV=4.
- dnum=0, par=10, snum=1, din=0xA5 -> 7 data bits 1,0,1,0,0,1,0; din[7] not sent; parity bit 1; stop high 8 clk. Total 44 clk.
- din_valid held high with bytes 0x01 then 0x02 -> second start bit falls exactly 2 clk after the last stop-bit cycle of the first frame (1 idle cycle). Each byte is sent exactly once.
- bd_rate switched from 00 to 01 mid-frame (DIV1=6) -> current frame keeps 4-clk bits; next accepted frame uses 6-clk bits.
- rst asserted asynchronously during DATA bit 3 -> dout=1 and din_ready=1 immediately, with no clock edge required; after release the next accept sends a clean full frame.

Source files
------------

// File: rtl/uart_tx_framer.sv
`default_nettype none
// ============================================================================
// Module   : uart_tx_framer
// Purpose  : Serial transmit framer. It accepts one byte per valid/ready
//            handshake and sends it as a start bit, 7 or 8 data bits (LSB
//            first), an optional parity bit, and then 1 or 2 stop bits.
//            The bit period comes from a down-counter on the system clock.
// Ports    : clk, rst (async, active-high)
//            bd_rate[1:0] - selects the bit period (DIV0..DIV3 clocks)
//            dnum         - 0: 7 data bits, 1: 8 data bits
//            snum         - 0: 1 stop bit,  1: 2 stop bits
//            par[1:0]     - 00/11 none, 01 odd, 10 even
//            din[7:0], din_valid, din_ready - byte input handshake
//            dout         - serial line, idles high
//            tx_busy      - a frame is in progress
//            tx_done      - one-cycle pulse in the first idle cycle
// Revision : 1.0 - initial release
// ============================================================================
module uart_tx_framer #(
    parameter int DIV0 = 5208,
    parameter int DIV1 = 2604,
    parameter int DIV2 = 1302,
    parameter int DIV3 = 434
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [1:0] bd_rate,
    input  logic       dnum,
    input  logic       snum,
    input  logic [1:0] par,
    input  logic [7:0] din,
    input  logic       din_valid,
    output logic       din_ready,
    output logic       dout,
    output logic       tx_busy,
    output logic       tx_done
);

    // The counter must be wide enough for the largest divisor.
    localparam int c_MAX01  = (DIV0 > DIV1) ? DIV0 : DIV1;
    localparam int c_MAX23  = (DIV2 > DIV3) ? DIV2 : DIV3;
    localparam int c_MAXDIV = (c_MAX01 > c_MAX23) ? c_MAX01 : c_MAX23;
    localparam int c_CW     = $clog2(c_MAXDIV + 1);

    localparam logic [c_CW-1:0] c_ONE = c_CW'(1);

    localparam logic [2:0] c_IDLE   = 3'd0;
    localparam logic [2:0] c_START  = 3'd1;
    localparam logic [2:0] c_DATA   = 3'd2;
    localparam logic [2:0] c_PARITY = 3'd3;
    localparam logic [2:0] c_STOP   = 3'd4;

    logic [2:0]      r_state;
    logic [c_CW-1:0] r_cnt;
    logic [c_CW-1:0] r_div;
    logic [7:0]      r_data;
    logic [2:0]      r_idx;
    logic            r_dnum;
    logic            r_snum;
    logic            r_par_en;
    logic            r_par_bit;
    logic            r_stop_idx;
    logic            r_dout;
    logic            r_ready;
    logic            r_busy;
    logic            r_done;

    logic [c_CW-1:0] w_div_sel;
    logic            w_xor;
    logic [2:0]      w_next_idx;
    logic [2:0]      w_last_idx;

    always_comb begin
        w_div_sel = c_CW'(DIV0);
        case (bd_rate)
            2'b00:   w_div_sel = c_CW'(DIV0);
            2'b01:   w_div_sel = c_CW'(DIV1);
            2'b10:   w_div_sel = c_CW'(DIV2);
            default: w_div_sel = c_CW'(DIV3);
        endcase
    end

    // Parity covers only the bits that actually go on the line.
    assign w_xor      = dnum ? (^din) : (^din[6:0]);
    assign w_next_idx = r_idx + 3'd1;
    assign w_last_idx = r_dnum ? 3'd7 : 3'd6;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state    <= c_IDLE;
            r_cnt      <= '0;
            r_div      <= '0;
            r_data     <= '0;
            r_idx      <= '0;
            r_dnum     <= 1'b0;
            r_snum     <= 1'b0;
            r_par_en   <= 1'b0;
            r_par_bit  <= 1'b0;
            r_stop_idx <= 1'b0;
            r_dout     <= 1'b1;
            r_ready    <= 1'b1;
            r_busy     <= 1'b0;
            r_done     <= 1'b0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                c_IDLE: begin
                    r_dout <= 1'b1;
                    if (din_valid && r_ready) begin
                        r_data     <= din;
                        r_dnum     <= dnum;
                        r_snum     <= snum;
                        r_par_en   <= (par == 2'b01) || (par == 2'b10);
                        // Odd mode inverts the data XOR so the total is odd.
                        r_par_bit  <= (par == 2'b01) ? ~w_xor : w_xor;
                        r_div      <= w_div_sel;
                        r_cnt      <= w_div_sel - c_ONE;
                        r_idx      <= '0;
                        r_stop_idx <= 1'b0;
                        r_state    <= c_START;
                        r_dout     <= 1'b0;
                        r_ready    <= 1'b0;
                        r_busy     <= 1'b1;
                    end
                end
                default: begin
                    if (r_cnt != '0) begin
                        r_cnt <= r_cnt - c_ONE;
                    end else begin
                        // Bit boundary: reload the period for the next bit.
                        r_cnt <= r_div - c_ONE;
                        case (r_state)
                            c_START: begin
                                r_state <= c_DATA;
                                r_idx   <= '0;
                                r_dout  <= r_data[0];
                            end
                            c_DATA: begin
                                if (r_idx == w_last_idx) begin
                                    if (r_par_en) begin
                                        r_state <= c_PARITY;
                                        r_dout  <= r_par_bit;
                                    end else begin
                                        r_state <= c_STOP;
                                        r_dout  <= 1'b1;
                                    end
                                end else begin
                                    r_idx  <= w_next_idx;
                                    r_dout <= r_data[w_next_idx];
                                end
                            end
                            c_PARITY: begin
                                r_state <= c_STOP;
                                r_dout  <= 1'b1;
                            end
                            c_STOP: begin
                                if (r_snum && !r_stop_idx) begin
                                    r_stop_idx <= 1'b1;
                                end else begin
                                    r_state <= c_IDLE;
                                    r_dout  <= 1'b1;
                                    r_ready <= 1'b1;
                                    r_busy  <= 1'b0;
                                    r_done  <= 1'b1;
                                end
                            end
                            default: begin
                                // Unreachable encodings recover to idle.
                                r_state <= c_IDLE;
                                r_dout  <= 1'b1;
                                r_ready <= 1'b1;
                                r_busy  <= 1'b0;
                            end
                        endcase
                    end
                end
            endcase
        end
    end

    assign dout      = r_dout;
    assign din_ready = r_ready;
    assign tx_busy   = r_busy;
    assign tx_done   = r_done;

endmodule
`default_nettype wire

// File: tb/tb_uart_tx_framer.sv
`default_nettype none
// ============================================================================
// Module   : tb_uart_tx_framer
// Purpose  : Self-checking bench for uart_tx_framer. A frame-level model
//            predicts the line/handshake outputs for every cycle; directed
//            frames with literal bit patterns pin the model itself.
// Revision : 1.0 - initial release
// ============================================================================
module tb_uart_tx_framer;

    localparam int DIV0 = 4;
    localparam int DIV1 = 6;
    localparam int DIV2 = 3;
    localparam int DIV3 = 2;

    typedef struct packed {
        logic dout;
        logic ready;
        logic busy;
        logic done;
    } obs_t;

    localparam obs_t c_IDLE_OBS = 4'b1100;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [1:0] bd_rate = 2'b00;
    logic       dnum = 1'b1;
    logic       snum = 1'b0;
    logic [1:0] par = 2'b00;
    logic [7:0] din = 8'h00;
    logic       din_valid = 1'b0;
    logic       din_ready;
    logic       dout;
    logic       tx_busy;
    logic       tx_done;

    int checks = 0;
    int errors = 0;

    obs_t cur = c_IDLE_OBS;
    obs_t q[$];

    uart_tx_framer #(
        .DIV0(DIV0),
        .DIV1(DIV1),
        .DIV2(DIV2),
        .DIV3(DIV3)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .bd_rate  (bd_rate),
        .dnum     (dnum),
        .snum     (snum),
        .par      (par),
        .din      (din),
        .din_valid(din_valid),
        .din_ready(din_ready),
        .dout     (dout),
        .tx_busy  (tx_busy),
        .tx_done  (tx_done)
    );

    always #5 clk = ~clk;

    initial begin
        if (DIV0 < 2 || DIV1 < 2 || DIV2 < 2 || DIV3 < 2) begin
            $display("FAIL elaboration: divisor below 2");
            $fatal(1, "unsupported divisor");
        end
    end

    // Expand one accepted byte into the per-cycle output sequence it implies.
    task automatic push_frame(input logic [7:0] b, input logic dn, input logic sn,
                              input logic [1:0] p, input logic [1:0] bd);
        int   div;
        int   ones;
        int   nd;
        logic bits[$];
        case (bd)
            2'b00:   div = DIV0;
            2'b01:   div = DIV1;
            2'b10:   div = DIV2;
            default: div = DIV3;
        endcase
        nd   = dn ? 8 : 7;
        ones = 0;
        bits.push_back(1'b0);
        for (int i = 0; i < nd; i++) begin
            bits.push_back(b[i]);
            if (b[i]) ones++;
        end
        if (p == 2'b10) bits.push_back((ones % 2) == 1);
        else if (p == 2'b01) bits.push_back((ones % 2) == 0);
        bits.push_back(1'b1);
        if (sn) bits.push_back(1'b1);
        foreach (bits[j]) begin
            for (int k = 0; k < div; k++) q.push_back(obs_t'({bits[j], 3'b010}));
        end
        q.push_back(obs_t'(4'b1101));
    endtask

    // Reference model: advances once per clock, cleared by reset at any time.
    always @(posedge clk or posedge rst) begin
        if (rst) begin
            q.delete();
            cur = c_IDLE_OBS;
        end else begin
            if (cur.ready && din_valid) push_frame(din, dnum, snum, par, bd_rate);
            if (q.size() > 0) cur = q.pop_front();
            else cur = c_IDLE_OBS;
        end
    end

    always @(negedge clk) begin
        checks++;
        if ({dout, din_ready, tx_busy, tx_done} !== cur) begin
            errors++;
            $display("FAIL model t=%0t dout/ready/busy/done got %b expected %b",
                     $time, {dout, din_ready, tx_busy, tx_done}, cur);
        end
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic wait_idle();
        int n;
        n = 0;
        @(negedge clk);
        while (!(q.size() == 0 && cur == c_IDLE_OBS) && n < 500) begin
            @(negedge clk);
            n++;
        end
        if (n >= 500) begin
            checks++;
            errors++;
            $display("FAIL wait_idle: got timeout expected idle");
        end
    endtask

    // Send one byte and compare the line against a hand-written bit pattern.
    // Inputs are scrambled right after the accept to show they are ignored.
    task automatic send_literal(input string name, input logic [7:0] b,
                                input logic dn, input logic sn,
                                input logic [1:0] p, input logic [1:0] bd,
                                input int nbits, input logic [63:0] exp_bits);
        logic [63:0] rec;
        int          done_at;
        wait_idle();
        din = b; dnum = dn; snum = sn; par = p; bd_rate = bd; din_valid = 1'b1;
        rec     = '0;
        done_at = -1;
        for (int i = 1; i <= nbits + 2; i++) begin
            @(negedge clk);
            if (i == 1) begin
                din_valid = 1'b0;
                din = ~b; dnum = ~dn; snum = ~sn; par = ~p; bd_rate = ~bd;
            end
            if (i <= nbits) rec = {rec[62:0], dout};
            if (tx_done && done_at < 0) done_at = i;
        end
        chk({name, " bits"}, rec, exp_bits);
        chk({name, " done cycle"}, 64'(done_at), 64'(nbits + 1));
    endtask

    initial begin
        logic [63:0] rec1;
        logic [63:0] rec2;

        @(negedge clk);
        chk("reset state", {60'd0, dout, din_ready, tx_busy, tx_done}, 64'b1100);
        @(negedge clk);
        rst = 1'b0;

        // 0x55, 8N1 at 4 clocks/bit.
        send_literal("frame 55 8N1", 8'h55, 1'b1, 1'b0, 2'b00, 2'b00, 40, 64'h0F0F0F0F0F);
        // 0xA5, 8 bits, even parity -> parity 0; odd -> parity 1.
        send_literal("frame A5 even", 8'hA5, 1'b1, 1'b0, 2'b10, 2'b00, 44, 64'h0F0F00F0F0F);
        send_literal("frame A5 odd", 8'hA5, 1'b1, 1'b0, 2'b01, 2'b00, 44, 64'h0F0F00F0FFF);
        // 0xA5, 7 bits, even parity, 2 stops: parity 1, bit 7 not sent.
        send_literal("frame A5 7E2", 8'hA5, 1'b0, 1'b1, 2'b10, 2'b00, 44, 64'h0F0F00F0FFF);
        // Previous frame changed bd_rate mid-frame; this one uses 6-clock bits.
        send_literal("frame 55 div1", 8'h55, 1'b1, 1'b0, 2'b00, 2'b01, 60, 64'h03F03F03F03F03F);
        // Fastest rate with par=11 means no parity.
        send_literal("frame 55 div3 p11", 8'h55, 1'b1, 1'b0, 2'b11, 2'b11, 20, 64'h33333);

        // Back-to-back with din_valid held high.
        wait_idle();
        din = 8'h01; dnum = 1'b1; snum = 1'b0; par = 2'b00; bd_rate = 2'b00; din_valid = 1'b1;
        rec1 = '0;
        rec2 = '0;
        for (int i = 1; i <= 84; i++) begin
            @(negedge clk);
            if (i == 1) din = 8'h02;
            if (i == 79) din_valid = 1'b0;
            if (i <= 40) rec1 = {rec1[62:0], dout};
            else if (i >= 42 && i <= 81) rec2 = {rec2[62:0], dout};
            if (i == 41) chk("b2b gap cycle", {62'd0, dout, tx_done}, 64'b11);
            if (i == 42) chk("b2b second start", {62'd0, dout, din_ready}, 64'b00);
            if (i == 82) chk("b2b second done", {63'd0, tx_done}, 64'd1);
            if (i == 83) chk("b2b no third", {61'd0, dout, din_ready, tx_busy}, 64'b110);
        end
        chk("b2b first bits", rec1, 64'h0F0000000F);
        chk("b2b second bits", rec2, 64'h00F000000F);

        // Asynchronous reset during data bit 3.
        wait_idle();
        din = 8'h55; dnum = 1'b1; snum = 1'b0; par = 2'b00; bd_rate = 2'b00; din_valid = 1'b1;
        for (int i = 1; i <= 18; i++) begin
            @(negedge clk);
            if (i == 1) din_valid = 1'b0;
        end
        chk("pre-reset busy", {63'd0, tx_busy}, 64'd1);
        #2 rst = 1'b1;
        #1 chk("async reset", {60'd0, dout, din_ready, tx_busy, tx_done}, 64'b1100);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        send_literal("after reset", 8'h55, 1'b1, 1'b0, 2'b00, 2'b00, 40, 64'h0F0F0F0F0F);

        // Randomized traffic: every input may change every cycle.
        wait_idle();
        for (int c = 0; c < 6000; c++) begin
            din       = 8'($urandom);
            dnum      = 1'($urandom);
            snum      = 1'($urandom);
            par       = 2'($urandom);
            bd_rate   = 2'($urandom);
            din_valid = ($urandom_range(0, 3) != 0);
            @(negedge clk);
        end
        din_valid = 1'b0;
        wait_idle();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
